// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and widths for the pipeline stall/flush controller
package pipeline_ctrl_pkg;

  localparam int CNT_W = 32;
  localparam int REG_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stall/flush/status outputs of the pipeline controller
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ack;

  logic             stall_pc;
  logic             stall_ifid;
  logic             stall_idex;
  logic             stall_exmem;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_memwb;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: presents hazard sources, consumes control
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ack,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid,
           flush_idex, flush_memwb, mem_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, mem_req, mem_ack,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid,
           flush_idex, flush_memwb, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use hazard detection between ID and EX
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  output logic             lu_o
);

  logic hit_rs1;
  logic hit_rs2;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    hit_rs1 = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    hit_rs2 = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    lu_o    = ex_mem_read_i && (ex_rd_i != '0) && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central stall/flush controller with memory-wait FSM, timeout and perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  pipeline_ctrl_if.slave ctl_if
);

  localparam int TMO_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [TMO_W-1:0] WAIT_MAX_C = TMO_W'(WAIT_MAX);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic memstall;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex, flush_memwb;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (ctl_if.id_rs1),
    .id_rs2_i      (ctl_if.id_rs2),
    .id_use_rs1_i  (ctl_if.id_use_rs1),
    .id_use_rs2_i  (ctl_if.id_use_rs2),
    .ex_rd_i       (ctl_if.ex_rd),
    .ex_mem_read_i (ctl_if.ex_mem_read),
    .lu_o          (lu)
  );

  // Priority mux: memory freeze beats redirect beats load-use; all quiet in reset
  always_comb begin
    memstall    = ctl_if.mem_req && !ctl_if.mem_ack;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    if (Rst_n) begin
      if (memstall) begin
        // EX and ID re-present next cycle, so their requests are deferred
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (ctl_if.ex_redirect) begin
        // ID instruction is wrong-path, so its load-use hazard is moot
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end else if (lu) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end
    end
  end

  // Next-state for the memory-wait FSM, timeout counter, sticky error and perf counters
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_pc);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_ifid);
    case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MEM_WAIT;
          tmo_d   = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (ctl_if.mem_ack) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_q == WAIT_MAX_C) begin
          // Drop back to RUN; a still-pending request re-arms the wait next cycle
          err_d   = 1'b1;
          state_d = RUN;
          tmo_d   = '0;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        tmo_d   = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctl_if.stall_pc    = stall_pc;
  assign ctl_if.stall_ifid  = stall_ifid;
  assign ctl_if.stall_idex  = stall_idex;
  assign ctl_if.stall_exmem = stall_exmem;
  assign ctl_if.flush_ifid  = flush_ifid;
  assign ctl_if.flush_idex  = flush_idex;
  assign ctl_if.flush_memwb = flush_memwb;
  assign ctl_if.mem_err     = err_q;
  assign ctl_if.stall_cnt   = stall_cnt_q;
  assign ctl_if.flush_cnt   = flush_cnt_q;

endmodule
